// File: rtl/heap_pkg.sv
// Shared constants for the heap scheduler: action codes, default widths and FSM state encodings.
package heap_pkg;

  localparam int unsigned DEF_N          = 4;
  localparam int unsigned DEF_DW         = 12;
  localparam int unsigned DEF_AW         = 4;
  localparam int unsigned DEF_IW         = 8;
  localparam int unsigned DEF_MAX_ARRAYS = 16;
  localparam int unsigned DEF_TIMEOUT    = 64;

  localparam logic [7:0] ACT_RESET = 8'd1;
  localparam logic [7:0] ACT_ALLOC = 8'd2;
  localparam logic [7:0] ACT_FREE  = 8'd3;
  localparam logic [7:0] ACT_READ  = 8'd4;
  localparam logic [7:0] ACT_WRITE = 8'd5;
  localparam logic [7:0] ACT_SIZE  = 8'd6;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/heap_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward from ptr+1 (mod N).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [PW-1:0] cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        winner      = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/heap_scheduler.sv
// Arbitrates N requesters onto one heap action port and tracks the live array count.
// Optional WAIT timeout enabled by defining HEAP_SCHED_TIMEOUT_EN.
module heap_scheduler
  import heap_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned IW         = DEF_IW,
  parameter int unsigned MAX_ARRAYS = DEF_MAX_ARRAYS,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*8-1:0]  reqAction,
  input  logic [N*AW-1:0] reqArray,
  input  logic [N*IW-1:0] reqIndex,
  input  logic [N*DW-1:0] reqData,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rspValid,
  output logic [DW-1:0]   rspData,
  output logic            rspError,
  output logic [7:0]      heapAction,
  output logic [AW-1:0]   heapArray,
  output logic [IW-1:0]   heapIndex,
  output logic [DW-1:0]   heapIn,
  output logic            heapStart,
  input  logic            heapDone,
  input  logic [DW-1:0]   heapOut,
  output logic            busy,
  output logic [7:0]      allocatedArrays
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d;
  logic [7:0]    act_q, act_d;
  logic [AW-1:0] arr_q, arr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] in_q, in_d;
  logic          start_q, start_d;
  logic [N-1:0]  rspv_q, rspv_d;
  logic [DW-1:0] rspd_q, rspd_d;
  logic          rspe_q, rspe_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [N-1:0]  arb_grant;
  logic [PW-1:0] arb_win;
  logic          arb_valid;
  int unsigned   wsel;
  logic [7:0]    sel_act;
  logic          legal;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .grant  (arb_grant),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  assign wsel    = 32'(arb_win);
  assign sel_act = reqAction[wsel*8 +: 8];

  // Allocation limits are checked against the current count; it cannot move while IDLE.
  always_comb begin
    legal = 1'b0;
    case (sel_act)
      ACT_RESET, ACT_READ, ACT_WRITE, ACT_SIZE: legal = 1'b1;
      ACT_ALLOC: legal = (cnt_q != 8'(MAX_ARRAYS));
      ACT_FREE:  legal = (cnt_q != '0);
      default:   legal = 1'b0;
    endcase
  end

`ifdef HEAP_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    act_d   = act_q;
    arr_d   = arr_q;
    idx_d   = idx_q;
    in_d    = in_q;
    start_d = 1'b0;
    rspv_d  = '0;
    rspd_d  = rspd_q;
    rspe_d  = rspe_q;
    cnt_d   = cnt_q;
`ifdef HEAP_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d = arb_win;
          if (legal) begin
            state_d = ST_ISSUE;
            act_d   = sel_act;
            arr_d   = reqArray[wsel*AW +: AW];
            idx_d   = reqIndex[wsel*IW +: IW];
            in_d    = reqData[wsel*DW +: DW];
            start_d = 1'b1;
          end else begin
            state_d = ST_RESP;
            rspv_d  = arb_grant;
            rspd_d  = '0;
            rspe_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef HEAP_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (heapDone) begin
          state_d       = ST_RESP;
          rspv_d[win_q] = 1'b1;
          rspd_d        = heapOut;
          rspe_d        = 1'b0;
          act_d         = '0;
          arr_d         = '0;
          idx_d         = '0;
          in_d          = '0;
          case (act_q)
            ACT_RESET: cnt_d = '0;
            ACT_ALLOC: cnt_d = cnt_q + 8'd1;
            ACT_FREE:  cnt_d = cnt_q - 8'd1;
            default:   cnt_d = cnt_q;
          endcase
        end
`ifdef HEAP_SCHED_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d       = ST_RESP;
          rspv_d[win_q] = 1'b1;
          rspd_d        = '0;
          rspe_d        = 1'b1;
          act_d         = '0;
          arr_d         = '0;
          idx_d         = '0;
          in_d          = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = win_q;
        rspd_d  = '0;
        rspe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N - 1);
      win_q   <= '0;
      act_q   <= '0;
      arr_q   <= '0;
      idx_q   <= '0;
      in_q    <= '0;
      start_q <= 1'b0;
      rspv_q  <= '0;
      rspd_q  <= '0;
      rspe_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef HEAP_SCHED_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      act_q   <= act_d;
      arr_q   <= arr_d;
      idx_q   <= idx_d;
      in_q    <= in_d;
      start_q <= start_d;
      rspv_q  <= rspv_d;
      rspd_q  <= rspd_d;
      rspe_q  <= rspe_d;
      cnt_q   <= cnt_d;
`ifdef HEAP_SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // gnt is combinational off the IDLE scan; masked so nothing toggles while reset is held.
  assign gnt             = (state_q == ST_IDLE && !reset) ? arb_grant : '0;
  assign rspValid        = rspv_q;
  assign rspData         = rspd_q;
  assign rspError        = rspe_q;
  assign heapAction      = act_q;
  assign heapArray       = arr_q;
  assign heapIndex       = idx_q;
  assign heapIn          = in_q;
  assign heapStart       = start_q;
  assign busy            = (state_q != ST_IDLE);
  assign allocatedArrays = cnt_q;

endmodule

// File: doc/heap_scheduler.md
Name: heap_scheduler

Overview:
- Shares one heap memory port between N requesters (test-program executors, I/O channel movers).
- Round-robin arbitration; sequences each heap operation: issue, wait for completion, return result.
- Tracks the live allocated-array count and rejects illegal allocate/free requests before they reach the heap.
- Sits between the requesters and the heap memory module; it is the only driver of the heap action port.

Parameters:
- N, 4, number of requesters.
- DW, 12, data width.
- AW, 4, array-number width.
- IW, 8, element-index width.
- MAX_ARRAYS, 16, allocation ceiling for allocatedArrays.
- TIMEOUT, 64, heap wait limit in cycles; used only with the optional feature.

Ports:
- clock in 1: single clock; all logic on posedge.
- reset in 1: asynchronous, active-high.
- req in N: per-requester request.
- reqAction in N*8: packed action codes; requester i at [8i+7:8i].
- reqArray in N*AW: packed array numbers.
- reqIndex in N*IW: packed element indices.
- reqData in N*DW: packed write data.
- gnt out N: one-hot, one-cycle acceptance pulse.
- rspValid out N: one-hot, one-cycle response pulse.
- rspData out DW: result data, valid with rspValid.
- rspError out 1: error flag, valid with rspValid.
- heapAction out 8: action code to heap.
- heapArray out AW: array number to heap.
- heapIndex out IW: element index to heap.
- heapIn out DW: write data to heap.
- heapStart out 1: one-cycle operation strobe.
- heapDone in 1: heap completion pulse.
- heapOut in DW: heap read data, valid with heapDone.
- busy out 1: high in any state except IDLE.
- allocatedArrays out 8: live allocated-array count.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = N-1, so requester 0 has first priority.
- Reset mid-operation aborts it; no response is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, choose the first set bit scanning upward from pointer+1 (mod N).
  - Latch that requester's action/array/index/data; pulse gnt[winner] for that cycle.
  - Go to ISSUE. Rejected requests skip ISSUE and WAIT and go straight to RESP with error (see Action rules).
- ISSUE:
  - heapStart=1 for exactly one cycle; heapAction/heapArray/heapIndex/heapIn are driven from the latched values.
  - heap* outputs hold those values until RESP, then return to 0.
- WAIT: sample heapDone from the cycle after ISSUE. On heapDone, latch heapOut and go to RESP.
- RESP:
  - rspValid[winner]=1 for one cycle, with rspData and rspError.
  - pointer = winner; go to IDLE.
- Minimum latency: 4 cycles from req to rspValid when heapDone arrives in the first WAIT cycle. Back-to-back grants are at most one every 4 cycles.
- Requester handshake:
  - Hold req and operands stable until gnt.
  - Dropping req before gnt is a legal withdrawal.
  - A req still held after gnt is a new request.
- heapDone outside WAIT is ignored.
- Action codes (package constants):
  - 1 = RESET: allocatedArrays <- 0 on completion.
  - 2 = ALLOC: if allocatedArrays == MAX_ARRAYS, reject with error; otherwise +1 on completion, and rspData = heapOut (new array number).
  - 3 = FREE: if allocatedArrays == 0, reject with error; otherwise -1 on completion.
  - 4 = READ: rspData = heapOut.
  - 5 = WRITE.
  - 6 = SIZE: rspData = heapOut.
  - Any other code: rejected with error.
- Rejected requests: rspError=1, rspData=0, no heapStart, counter unchanged.
- Same-cycle events: gnt and the counter update never coincide for different requests, because the FSM serialises all operations.

Optional Feature:
- Macro: HEAP_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT counter counts from 0.
  - If TIMEOUT cycles pass without heapDone, go to RESP with rspError=1, rspData=0, counter unchanged.
  - A heapDone arriving later is ignored.
- Undefined: WAIT waits indefinitely; no counter logic is synthesised.

Decomposition:
- heap_pkg:
  - Action code constants: ACT_RESET=1, ACT_ALLOC=2, ACT_FREE=3, ACT_READ=4, ACT_WRITE=5, ACT_SIZE=6.
  - State typedef (IDLE/ISSUE/WAIT/RESP).
  - Default width constants.
- Sub-module rr_arbiter: inputs req[N] and pointer; outputs one-hot grant and winner index; purely combinational.

Test Plan:
- Reset, then req=4'b0001 with WRITE, array 0, index 3, data 5; heapDone one cycle after heapStart:
  - gnt[0] at cycle 1; heapStart at cycle 2 with heapIn=5; rspValid[0] at cycle 4; rspError=0.
- req=4'b1111 held, all READ, heap completes immediately:
  - grant order 0,1,2,3,0; each requester gets rspValid with its own heapOut value.
- ALLOC issued MAX_ARRAYS+1 times, heapOut = 0,1,...:
  - allocatedArrays reaches 16; the 17th gives rspError=1, no heapStart, count stays 16.
- FREE at count 0 -> rspError=1, no heapStart. Action code 9 -> rspError=1, rspData=0.
- Then RESET action at count 5 -> allocatedArrays=0 on completion.
- Assert reset during WAIT:
  - all outputs 0 immediately, no rspValid.
  - Next req=4'b0100 gets gnt[2] first; pointer reset to N-1 means scanning starts at 0, finds 2.
- With HEAP_SCHED_TIMEOUT_EN and TIMEOUT=64, heapDone never asserted:
  - rspValid with rspError=1 after 64 WAIT cycles.
  - A heapDone pulse 10 cycles later produces no response.
